key_expand_seq: RTL and testbench

//  Iterative AES-128 forward key expansion: takes cipher key (round key 0), derives round keys 1..10 at one per clock.

---
 rtl/aes_pkg.sv | 73 +++++++
 rtl/key_round_fwd.sv | 31 +++
 rtl/key_expand_seq.sv | 109 ++++++++++
 tb/tb_key_expand_seq.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: round-key type, round count, S-box, RCON.
// Used by the forward key expander and its round sub-module.
package aes_pkg;

  localparam int NR = 10;
  localparam int KW = 128;

  typedef logic [KW-1:0] key_t;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,
    8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,
    8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,
    8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,
    8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,
    8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,
    8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,
    8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,
    8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,
    8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,
    8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,
    8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,
    8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,
    8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,
    8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,
    8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,
    8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  function automatic logic [7:0] sbox(
    input logic [7:0] b
  );
    return SBOX[b];
  endfunction

  // Round constant for rounds 1..10; index 0 and 11..15 unused.
  function automatic logic [7:0] rcon_of(
    input logic [3:0] r
  );
    logic [7:0] v;
    v = 8'h00;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/key_round_fwd.sv
// One forward AES-128 key-schedule round (combinational).
// Ports: key (previous round key), rcon (round constant), nxt (next key).
module key_round_fwd
  import aes_pkg::*;
(
  input  key_t       key,
  input  logic [7:0] rcon,
  output key_t       nxt
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, sub, t;
  logic [31:0] n0, n1, n2, n3;

  assign w0 = key[127:96];
  assign w1 = key[95:64];
  assign w2 = key[63:32];
  assign w3 = key[31:0];

  assign rot = {w3[23:0], w3[31:24]};
  assign sub = {sbox(rot[31:24]), sbox(rot[23:16]),
                sbox(rot[15:8]),  sbox(rot[7:0])};
  assign t   = sub ^ {rcon, 24'h0};

  assign n0  = w0 ^ t;
  assign n1  = w1 ^ n0;
  assign n2  = w2 ^ n1;
  assign n3  = w3 ^ n2;
  assign nxt = {n0, n1, n2, n3};

endmodule

// File: rtl/key_expand_seq.sv
// Iterative AES-128 forward key expansion, one round key per clock,
// all 11 keys held in a register file with a random-access read port.
// Ports: clk, rst_n (sync, active low), key_in/in_valid/in_ready accept,
// busy, key_valid, key_last (round key 10), rd_addr/rd_key read port.
// Option: define KEYEXP_RD_REG_EN to register rd_key (1-cycle latency).
module key_expand_seq
  import aes_pkg::*;
#(
  parameter int KEY_W = 128,
  parameter int NR_P  = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  key_t       key_in,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       busy,
  output logic       key_valid,
  output key_t       key_last,
  input  logic [3:0] rd_addr,
  output key_t       rd_key
);

  if (KEY_W != 128 || NR_P != NR) begin : g_bad_cfg
    $error("key_expand_seq: only AES-128 (KEY_W=128, NR=10)");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] round;
  key_t       work;
  key_t       nxt;
  key_t       store [0:10];
  key_t       rd_sel;
  logic       accept;

  key_round_fwd u_round (
    .key  (work),
    .rcon (rcon_of(round)),
    .nxt  (nxt)
  );

  assign in_ready  = (state == IDLE) || (state == DONE);
  assign busy      = (state == EXPAND);
  assign key_valid = (state == DONE);
  assign key_last  = store[10];
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      round <= 4'd0;
      work  <= '0;
      for (int i = 0; i <= 10; i++)
        store[i] <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            store[0] <= key_in;
            work     <= key_in;
            round    <= 4'd1;
            state    <= EXPAND;
          end
        end
        EXPAND: begin
          for (int i = 1; i <= 10; i++)
            if (round == 4'(i))
              store[i] <= nxt;
          work <= nxt;
          // Counter holds at 10 so it never wraps.
          if (round == 4'd10) begin
            state <= DONE;
          end else begin
            round <= round + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Mux over the 11 valid entries; 11..15 read as zero.
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i <= 10; i++)
      if (rd_addr == 4'(i))
        rd_sel = store[i];
  end

`ifdef KEYEXP_RD_REG_EN
  key_t rd_q;

  always_ff @(posedge clk) begin
    if (!rst_n) rd_q <= '0;
    else        rd_q <= rd_sel;
  end

  assign rd_key = rd_q;
`else
  assign rd_key = rd_sel;
`endif

endmodule

// File: tb/tb_key_expand_seq.sv
// Directed self-checking bench for key_expand_seq.
// FIPS-197 and all-zero key vectors, timing, restart, reset, read port.
module tb_key_expand_seq;

  logic         clk;
  logic         rst_n;
  logic [127:0] key_in;
  logic         in_valid;
  logic         in_ready;
  logic         busy;
  logic         key_valid;
  logic [127:0] key_last;
  logic [3:0]   rd_addr;
  logic [127:0] rd_key;

  int checks;
  int failures;

  localparam logic [127:0] K_FIPS  =
    128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] F_RK1   =
    128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] F_RK10  =
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] Z_RK1   =
    128'h62636363626363636263636362636363;
  localparam logic [127:0] Z_RK10  =
    128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  key_expand_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_in    (key_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .busy      (busy),
    .key_valid (key_valid),
    .key_last  (key_last),
    .rd_addr   (rd_addr),
    .rd_key    (rd_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [3:0] a,
                    output logic [127:0] v);
    rd_addr = a;
`ifdef KEYEXP_RD_REG_EN
    step();
`else
    #1;
`endif
    v = rd_key;
  endtask

  task automatic accept(input logic [127:0] k);
    key_in   = k;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!key_valid && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (!key_valid) begin
      failures++;
      $display("FAIL wait_valid timeout key_valid=%0b want 1",
               key_valid);
    end
  endtask

  task automatic test_reset();
    logic [127:0] v;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    key_in   = '0;
    rd_addr  = 4'd0;
    step();
    step();
    checks++;
    if ({in_ready, busy, key_valid} !== 3'b100) begin
      failures++;
      $display("FAIL reset_flags got=%b want=100",
               {in_ready, busy, key_valid});
    end
    checks++;
    if (key_last !== '0) begin
      failures++;
      $display("FAIL reset_key_last got=%h want=0", key_last);
    end
    rst_n = 1'b1;
    rd(4'd0, v);
    checks++;
    if (v !== '0) begin
      failures++;
      $display("FAIL reset_rd0 got=%h want=0", v);
    end
  endtask

  // FIPS key with in_valid held high (and key_in changed) during
  // expansion: must not restart, latency must be exactly 10 edges.
  task automatic test_fips_timing();
    logic [127:0] v;
    key_in   = K_FIPS;
    in_valid = 1'b1;
    step();
    key_in = '0;
    for (int k = 1; k <= 10; k++) begin
      if (k == 10) in_valid = 1'b0;
      checks++;
      if (key_valid !== 1'b0 || busy !== 1'b1 ||
          in_ready !== 1'b0) begin
        failures++;
        $display("FAIL expand_flags k=%0d got=%b want=010",
                 k, {in_ready, busy, key_valid});
      end
      step();
    end
    in_valid = 1'b0;
    checks++;
    if ({in_ready, busy, key_valid} !== 3'b101) begin
      failures++;
      $display("FAIL done_flags got=%b want=101",
               {in_ready, busy, key_valid});
    end
    checks++;
    if (key_last !== F_RK10) begin
      failures++;
      $display("FAIL fips_last got=%h want=%h",
               key_last, F_RK10);
    end
    rd(4'd1, v);
    checks++;
    if (v !== F_RK1) begin
      failures++;
      $display("FAIL fips_rd1 got=%h want=%h", v, F_RK1);
    end
    rd(4'd0, v);
    checks++;
    if (v !== K_FIPS) begin
      failures++;
      $display("FAIL fips_rd0 got=%h want=%h", v, K_FIPS);
    end
    rd(4'd10, v);
    checks++;
    if (v !== F_RK10) begin
      failures++;
      $display("FAIL fips_rd10 got=%h want=%h", v, F_RK10);
    end
  endtask

  // Accept zero key while in DONE.
  task automatic test_back_to_back();
    logic [127:0] v;
    accept('0);
    for (int k = 1; k <= 10; k++) begin
      checks++;
      if (key_valid !== 1'b0) begin
        failures++;
        $display("FAIL restart_valid k=%0d got=%b want=0",
                 k, key_valid);
      end
      step();
    end
    checks++;
    if (key_valid !== 1'b1) begin
      failures++;
      $display("FAIL restart_done got=%b want=1", key_valid);
    end
    checks++;
    if (key_last !== Z_RK10) begin
      failures++;
      $display("FAIL zero_last got=%h want=%h",
               key_last, Z_RK10);
    end
    rd(4'd1, v);
    checks++;
    if (v !== Z_RK1) begin
      failures++;
      $display("FAIL zero_rd1 got=%h want=%h", v, Z_RK1);
    end
    rd(4'd0, v);
    checks++;
    if (v !== '0) begin
      failures++;
      $display("FAIL zero_rd0 got=%h want=0", v);
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] v;
    accept(K_FIPS);
    for (int k = 1; k < 5; k++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if ({in_ready, busy, key_valid} !== 3'b100) begin
      failures++;
      $display("FAIL midrst_flags got=%b want=100",
               {in_ready, busy, key_valid});
    end
    checks++;
    if (key_last !== '0) begin
      failures++;
      $display("FAIL midrst_last got=%h want=0", key_last);
    end
    rd(4'd1, v);
    checks++;
    if (v !== '0) begin
      failures++;
      $display("FAIL midrst_rd1 got=%h want=0", v);
    end
    accept(K_FIPS);
    wait_valid();
    checks++;
    if (key_last !== F_RK10) begin
      failures++;
      $display("FAIL midrst_redo got=%h want=%h",
               key_last, F_RK10);
    end
  endtask

  task automatic test_read_port();
    logic [127:0] v;
    for (int a = 11; a <= 15; a++) begin
      rd(4'(a), v);
      checks++;
      if (v !== '0) begin
        failures++;
        $display("FAIL rd_oob a=%0d got=%h want=0", a, v);
      end
    end
`ifdef KEYEXP_RD_REG_EN
    rd(4'd10, v);
    rd_addr = 4'd1;
    #1;
    checks++;
    if (rd_key !== F_RK10) begin
      failures++;
      $display("FAIL rd_lag_hold got=%h want=%h",
               rd_key, F_RK10);
    end
    step();
    checks++;
    if (rd_key !== F_RK1) begin
      failures++;
      $display("FAIL rd_lag_next got=%h want=%h",
               rd_key, F_RK1);
    end
`endif
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_fips_timing();
    test_back_to_back();
    test_reset_mid();
    test_read_port();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
